// File: rtl/seq_fsm.sv
// seq_fsm: instruction sequencer for a byte-wide core.
// Fetches one instruction byte, lets the external decoder settle, performs an
// optional LDB/STB data access, then pulses exec for the datapath. A level
// halt request is taken only at the instruction boundary after EXEC.
//
// Memory handshake: mem_req is a request level. While mem_req=1, mem_addr,
// mem_we and mem_wdata are held stable until mem_ack is sampled high at a
// rising clk edge. mem_ack is a one-cycle completion pulse, and it may arrive
// in the first request cycle. mem_ack seen while mem_req=0 has no effect.
// mem_req drops in the cycle after the acknowledge.
module seq_fsm #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [7:0]  instr,
   input  logic        dec_fetch,
   input  logic        dec_we,
   input  logic [15:0] data_addr,
   input  logic [7:0]  data_wdata,
   output logic [7:0]  ld_data,
   output logic        ld_valid,
   output logic        exec,
   input  logic        halt,
   output logic        halted,
   output logic [15:0] pc,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEM    = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_live;     // low for the cycle(s) spent in reset; gates the first fetch
   logic [15:0] r_pc;
   logic [7:0]  r_instr;
   logic [7:0]  r_ld_data;
   logic        r_ld_flag;  // current instruction completed a load
   logic        w_fetch_done;
   logic        w_mem_done;

   assign w_fetch_done = (r_state == S_FETCH) && r_live && mem_ack;
   assign w_mem_done   = (r_state == S_MEM) && mem_ack;

   assign pc          = r_pc;
   assign instr       = r_instr;
   assign ld_data     = r_ld_data;
   assign o_dbg_state = r_state;

   // State register plus the pc, instruction and load-data registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_live    <= 1'b0;
         r_pc      <= RESET_PC;
         r_instr   <= 8'h00;
         r_ld_data <= 8'h00;
         r_ld_flag <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         if (w_fetch_done) begin
            r_instr <= mem_rdata;
            r_pc    <= r_pc + 16'd1;
         end
         if (w_mem_done && !dec_we) begin
            r_ld_data <= mem_rdata;
            r_ld_flag <= 1'b1;
         end else if (r_state == S_EXEC) begin
            r_ld_flag <= 1'b0;
         end
      end
   end

   // Next-state and output decode; idle bus shows pc and zero write data.
   always_comb begin
      w_state_nxt = r_state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = r_pc;
      mem_wdata   = 8'h00;
      exec        = 1'b0;
      ld_valid    = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req = r_live;
            if (w_fetch_done) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            w_state_nxt = dec_fetch ? S_MEM : S_EXEC;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_addr  = data_addr;
            mem_we    = dec_we;
            mem_wdata = data_wdata;
            if (w_mem_done) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            exec        = 1'b1;
            ld_valid    = r_ld_flag;
            w_state_nxt = halt ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (!halt) w_state_nxt = S_FETCH;
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_fsm.sv
// Directed bench for seq_fsm: reset, pc wrap, ALU, LDB with wait states,
// STB, halt at the instruction boundary, and reset during a pending access.
module tb_seq_fsm;

   localparam logic [15:0] TB_RESET_PC = 16'hFFFF;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [7:0]  instr;
   logic        dec_fetch;
   logic        dec_we;
   logic [15:0] data_addr;
   logic [7:0]  data_wdata;
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        exec;
   logic        halt;
   logic        halted;
   logic [15:0] pc;
   logic [2:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   seq_fsm #(.RESET_PC(TB_RESET_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .instr      (instr),
      .dec_fetch  (dec_fetch),
      .dec_we     (dec_we),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .exec       (exec),
      .halt       (halt),
      .halted     (halted),
      .pc         (pc),
      .o_dbg_state(dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // fetch cycle with zero wait states; caller is in FETCH
   task automatic fetch_ack(input logic [7:0] op, input logic [15:0] exp_addr, input string tag);
      mem_rdata = op;
      mem_ack   = 1'b1;
      #1;
      chk({tag, "_freq"},  {15'd0, mem_req}, 16'd1);
      chk({tag, "_fwe"},   {15'd0, mem_we},  16'd0);
      chk({tag, "_faddr"}, mem_addr, exp_addr);
      step();
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
      dec_fetch = 1'b0; dec_we = 1'b0; data_addr = 16'h0000; data_wdata = 8'h00;
      halt = 1'b0;
      step();
      step();
      #1;
      // reset state
      chk("rst_req",   {15'd0, mem_req},  16'd0);
      chk("rst_we",    {15'd0, mem_we},   16'd0);
      chk("rst_pc",    pc, TB_RESET_PC);
      chk("rst_addr",  mem_addr, TB_RESET_PC);
      chk("rst_wdata", {8'd0, mem_wdata}, 16'h0000);
      chk("rst_instr", {8'd0, instr},     16'h0000);
      chk("rst_lddat", {8'd0, ld_data},   16'h0000);
      chk("rst_exec",  {15'd0, exec},     16'd0);
      chk("rst_ldv",   {15'd0, ld_valid}, 16'd0);
      chk("rst_halt",  {15'd0, halted},   16'd0);

      // pc wrap: fetch at FFFF
      rst_n = 1'b1;
      step();
      fetch_ack(8'h01, 16'hFFFF, "wrap");
      #1;
      chk("wrap_pc",    pc, 16'h0000);
      chk("wrap_instr", {8'd0, instr}, 16'h0001);
      chk("wrap_dreq",  {15'd0, mem_req}, 16'd0);
      step();
      #1;
      chk("wrap_exec", {15'd0, exec}, 16'd1);
      step();
      #1;
      chk("wrap_exec0", {15'd0, exec}, 16'd0);

      // ALU instruction 8'h10 at pc 0: 3-cycle sequence
      fetch_ack(8'h10, 16'h0000, "alu");
      #1;
      chk("alu_instr", {8'd0, instr}, 16'h0010);
      chk("alu_pc",    pc, 16'h0001);
      chk("alu_idle_addr", mem_addr, 16'h0001);
      chk("alu_ex_early", {15'd0, exec}, 16'd0);
      step();
      #1;
      chk("alu_exec", {15'd0, exec}, 16'd1);
      chk("alu_ldv",  {15'd0, ld_valid}, 16'd0);
      step();

      // LDB at pc 1, data ack delayed 3 cycles
      fetch_ack(8'h20, 16'h0001, "ldb");
      dec_fetch = 1'b1; dec_we = 1'b0; data_addr = 16'h1234;
      step();
      mem_rdata = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ldb_wreq",  {15'd0, mem_req}, 16'd1);
         chk("ldb_waddr", mem_addr, 16'h1234);
         chk("ldb_wwe",   {15'd0, mem_we}, 16'd0);
         chk("ldb_wexec", {15'd0, exec}, 16'd0);
         step();
      end
      mem_rdata = 8'hA5; mem_ack = 1'b1;
      #1;
      chk("ldb_aaddr", mem_addr, 16'h1234);
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00; dec_fetch = 1'b0;
      #1;
      chk("ldb_exec",  {15'd0, exec}, 16'd1);
      chk("ldb_ldv",   {15'd0, ld_valid}, 16'd1);
      chk("ldb_data",  {8'd0, ld_data}, 16'h00A5);
      chk("ldb_reqlo", {15'd0, mem_req}, 16'd0);
      step();
      #1;
      chk("ldb_ldv0", {15'd0, ld_valid}, 16'd0);

      // STB at pc 2: 8'h3C to 16'h0040, one wait state
      fetch_ack(8'h30, 16'h0002, "stb");
      dec_fetch = 1'b1; dec_we = 1'b1; data_addr = 16'h0040; data_wdata = 8'h3C;
      step();
      for (int i = 0; i < 2; i++) begin
         if (i == 1) begin
            mem_ack = 1'b1; mem_rdata = 8'h99;
         end
         #1;
         chk("stb_we",    {15'd0, mem_we}, 16'd1);
         chk("stb_wdata", {8'd0, mem_wdata}, 16'h003C);
         chk("stb_addr",  mem_addr, 16'h0040);
         step();
      end
      mem_ack = 1'b0; mem_rdata = 8'h00; dec_fetch = 1'b0; dec_we = 1'b0; data_wdata = 8'h00;
      #1;
      chk("stb_exec",  {15'd0, exec}, 16'd1);
      chk("stb_ldv",   {15'd0, ld_valid}, 16'd0);
      chk("stb_lddat", {8'd0, ld_data}, 16'h00A5);
      step();

      // halt raised during MEM of an LDB at pc 3
      fetch_ack(8'h20, 16'h0003, "hlt");
      dec_fetch = 1'b1; dec_we = 1'b0; data_addr = 16'h1234;
      step();
      halt = 1'b1;
      #1;
      chk("hlt_mreq", {15'd0, mem_req}, 16'd1);
      step();
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00; dec_fetch = 1'b0;
      #1;
      chk("hlt_exec", {15'd0, exec}, 16'd1);
      chk("hlt_ldv",  {15'd0, ld_valid}, 16'd1);
      chk("hlt_data", {8'd0, ld_data}, 16'h005A);
      step();
      #1;
      chk("hlt_halted", {15'd0, halted}, 16'd1);
      chk("hlt_state",  {13'd0, dbg_state}, 16'd4);
      chk("hlt_req",    {15'd0, mem_req}, 16'd0);
      chk("hlt_pc",     pc, 16'h0004);
      // stray ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      #1;
      chk("hlt_stay",   {15'd0, halted}, 16'd1);
      chk("hlt_pc2",    pc, 16'h0004);
      chk("hlt_instr",  {8'd0, instr}, 16'h0020);
      halt = 1'b0;
      #1;
      chk("hlt_still",  {15'd0, halted}, 16'd1);
      step();
      #1;
      chk("hlt_rel",    {15'd0, halted}, 16'd0);
      chk("hlt_freq",   {15'd0, mem_req}, 16'd1);
      chk("hlt_faddr",  mem_addr, 16'h0004);

      // reset while MEM waits, with ack in the same cycle
      fetch_ack(8'h20, 16'h0004, "rmem");
      dec_fetch = 1'b1; dec_we = 1'b0; data_addr = 16'h1234;
      step();
      step();
      rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00; dec_fetch = 1'b0;
      #1;
      chk("rmem_req",   {15'd0, mem_req}, 16'd0);
      chk("rmem_ldv",   {15'd0, ld_valid}, 16'd0);
      chk("rmem_exec",  {15'd0, exec}, 16'd0);
      chk("rmem_pc",    pc, TB_RESET_PC);
      chk("rmem_lddat", {8'd0, ld_data}, 16'h0000);
      rst_n = 1'b1;
      step();
      #1;
      chk("rmem_freq",  {15'd0, mem_req}, 16'd1);
      chk("rmem_fwe",   {15'd0, mem_we}, 16'd0);
      chk("rmem_faddr", mem_addr, TB_RESET_PC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
